boot_loader: RTL

Byte-stream program loader that sits upstream of `cpu_top`. It receives a framed byte stream, typically from a UART receiver, and assembles big-endian 16-bit instruction words. It writes those words into instruction memory from address 0. It holds the CPU in reset until a complete frame with a valid checksum has been stored, then releases it.

---
 rtl/boot_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Framed byte-stream loader: hunts for an 0xA5 header, stores N big-endian words
// into instruction memory from address 0 and releases the CPU once the XOR checksum matches.
//
// state | meaning
// IDLE  | hunt for 0xA5 header, drop everything else
// LEN   | take word count N, reject 0 or N > capacity
// HI    | take high byte of a word
// LO    | take low byte, present the full word
// WR    | one-cycle memory write, rx stalled
// CSUM  | compare checksum byte with running XOR
// DONE  | frame verified, CPU released, bytes dropped
// ERR   | frame rejected, hunt for a new 0xA5
module boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  localparam logic [7:0]        HDR     = 8'hA5;
  localparam logic [9:0]        MAX_LEN = 10'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE_A   = 1;
  localparam logic [ADDR_W:0]   ONE_W   = 1;

  logic [2:0]      state;
  logic [ADDR_W:0] len_q;
  logic [7:0]      hi_q;
  logic [7:0]      xor_q;
  logic [8:0]      n_ext;
  logic            xfer;
  logic            len_bad;
  logic            last_word;

  assign n_ext     = {1'b0, rx_data};
  assign xfer      = rx_valid && rx_ready;
  assign len_bad   = (rx_data == 8'd0) || ({2'b00, rx_data} > MAX_LEN);
  assign last_word = (words_loaded + ONE_W) == len_q;

  assign rx_ready = (state != S_WR);
  assign imem_we  = (state == S_WR);
  assign cpu_rst  = (state != S_DONE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      err_code     <= 2'b00;
      words_loaded <= '0;
      len_q        <= '0;
      hi_q         <= '0;
      xor_q        <= '0;
    end else begin
      case (state)
        S_IDLE: if (xfer && rx_data == HDR) state <= S_LEN;
        S_LEN: if (xfer) begin
          if (len_bad) begin
            err_code <= 2'b01;
            state    <= S_ERR;
          end else begin
            // N never exceeds capacity here, so it fits in ADDR_W+1 bits
            len_q        <= n_ext[ADDR_W:0];
            imem_addr    <= '0;
            words_loaded <= '0;
            xor_q        <= '0;
            state        <= S_HI;
          end
        end
        S_HI: if (xfer) begin
          hi_q  <= rx_data;
          xor_q <= xor_q ^ rx_data;
          state <= S_LO;
        end
        S_LO: if (xfer) begin
          imem_wdata <= {hi_q, rx_data};
          xor_q      <= xor_q ^ rx_data;
          state      <= S_WR;
        end
        S_WR: begin
          imem_addr    <= imem_addr + ONE_A;
          words_loaded <= words_loaded + ONE_W;
          state        <= last_word ? S_CSUM : S_HI;
        end
        S_CSUM: if (xfer) begin
          if (rx_data == xor_q) begin
            state <= S_DONE;
          end else begin
            err_code <= 2'b10;
            state    <= S_ERR;
          end
        end
        S_DONE: state <= S_DONE;
        S_ERR: if (xfer && rx_data == HDR) begin
          err_code <= 2'b00;
          state    <= S_LEN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
